// File: rtl/buff_dly_pkg.sv
// Shared defaults and the depth-clamp helper for the programmable delay line.
package buff_dly_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int MAX_DEPTH_DEF = 8;
  localparam int CNT_W_DEF     = 16;
  localparam int DEF_DEPTH     = 6;

  // Map a requested delay onto the physical line: 0 becomes 1, anything
  // longer than the line becomes the full line length.
  function automatic int clamp_depth(input int sel, input int max_d);
    if (sel < 1) return 1;
    if (sel > max_d) return max_d;
    return sel;
  endfunction

endpackage

// File: rtl/buff_dly_if.sv
// Control, data and status bundle of the delay line.
// There is no flow control: every cycle with flush=0 and hold=0 the line
// advances and en qualifies in_data as a valid word; out_valid marks a
// valid word at the tap.
interface buff_dly_if
  import buff_dly_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DSEL_W = $clog2(MAX_DEPTH_DEF) + 1,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              en;
  logic              hold;
  logic              flush;
  logic [DSEL_W-1:0] depth_sel;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              primed;
  logic [DSEL_W-1:0] occ;
  logic [CNT_W-1:0]  lost_cnt;

  modport master (
    output en, hold, flush, depth_sel, in_data,
    input  out_data, out_valid, primed, occ, lost_cnt
  );

  modport slave (
    input  en, hold, flush, depth_sel, in_data,
    output out_data, out_valid, primed, occ, lost_cnt
  );
endinterface

// File: rtl/buff_dly_popcnt.sv
// Population count of a valid-flag vector.
module buff_dly_popcnt #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec,
  output logic [CW-1:0] cnt
);

  // Sum the set bits of the vector.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < W; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/buff_dly.sv
// Runtime-programmable delay line: a fixed shift register of MAX_DEPTH
// stages with an output tap at the clamped depth, priming and occupancy
// status, and a saturating count of valid words discarded by flush.
module buff_dly
  import buff_dly_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_DEPTH = MAX_DEPTH_DEF,
  parameter int DSEL_W    = $clog2(MAX_DEPTH) + 1,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  buff_dly_if.slave bus
);

  localparam logic [DSEL_W-1:0] DEF_EFF  = DSEL_W'(clamp_depth(DEF_DEPTH, MAX_DEPTH));
  localparam int                LW       = CNT_W + DSEL_W;
  localparam logic [LW-1:0]     LOST_MAX = LW'({CNT_W{1'b1}});

  // Index k-1 holds stage k.
  logic [DATA_W-1:0]    stage_data [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] stage_vld;

  logic [DSEL_W-1:0]    d_eff;
  logic [DSEL_W-1:0]    tap_idx;
  logic [DSEL_W-1:0]    prev_deff;
  logic [DSEL_W-1:0]    prime_cnt;
  logic [DSEL_W-1:0]    occ_cnt;
  logic [DSEL_W-1:0]    flush_pop;
  logic [MAX_DEPTH-1:0] tap_mask;
  logic [CNT_W-1:0]     lost_cnt;
  logic [LW-1:0]        lost_sum;
  logic                 advance;
  logic                 depth_chg;

  assign d_eff     = DSEL_W'(clamp_depth(int'(bus.depth_sel), MAX_DEPTH));
  assign tap_idx   = d_eff - DSEL_W'(1);
  assign advance   = !bus.flush && !bus.hold;
  assign depth_chg = (d_eff != prev_deff);

  // Shift register: flush wins over hold; an idle cycle inserts a zero bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_DEPTH; i++) stage_data[i] <= '0;
      stage_vld <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < MAX_DEPTH; i++) stage_data[i] <= '0;
      stage_vld <= '0;
    end else if (!bus.hold) begin
      stage_data[0] <= bus.en ? bus.in_data : '0;
      for (int i = 1; i < MAX_DEPTH; i++) stage_data[i] <= stage_data[i-1];
      stage_vld <= {stage_vld[MAX_DEPTH-2:0], bus.en};
    end
  end

  // Output tap selects registered stages only, so in_data/en never reach outputs.
  always_comb begin
    bus.out_data  = '0;
    bus.out_valid = 1'b0;
    for (int i = 0; i < MAX_DEPTH; i++) begin
      if (DSEL_W'(i) == tap_idx) begin
        bus.out_data  = stage_data[i];
        bus.out_valid = stage_vld[i];
      end
    end
  end

  // Stages 1..D_eff contribute to occupancy; deeper stages keep shifting unseen.
  always_comb begin
    tap_mask = '0;
    for (int i = 0; i < MAX_DEPTH; i++) tap_mask[i] = (DSEL_W'(i) < d_eff);
  end

  buff_dly_popcnt #(.W(MAX_DEPTH), .CW(DSEL_W)) u_occ_pop (
    .vec (stage_vld & tap_mask),
    .cnt (occ_cnt)
  );

  buff_dly_popcnt #(.W(MAX_DEPTH), .CW(DSEL_W)) u_flush_pop (
    .vec (stage_vld),
    .cnt (flush_pop)
  );

  // Prime counter restarts on flush or depth change, saturates at D_eff.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prime_cnt <= '0;
      prev_deff <= DEF_EFF;
    end else begin
      prev_deff <= d_eff;
      if (bus.flush || depth_chg) begin
        prime_cnt <= '0;
      end else if (advance && (prime_cnt < d_eff)) begin
        prime_cnt <= prime_cnt + DSEL_W'(1);
      end
    end
  end

  assign lost_sum = LW'(lost_cnt) + LW'(flush_pop);

  // Every flush charges all valid stages, including those beyond the tap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lost_cnt <= '0;
    end else if (bus.flush) begin
      lost_cnt <= (lost_sum > LOST_MAX) ? LOST_MAX[CNT_W-1:0] : lost_sum[CNT_W-1:0];
    end
  end

  assign bus.occ      = occ_cnt;
  assign bus.primed   = (prime_cnt >= d_eff);
  assign bus.lost_cnt = lost_cnt;

endmodule

// File: tb/tb_buff_dly.sv
// Directed bench for buff_dly (MAX_DEPTH=8, CNT_W=4 to reach saturation).
module tb_buff_dly;

  localparam int DATA_W    = 32;
  localparam int MAX_DEPTH = 8;
  localparam int DSEL_W    = 4;
  localparam int CNT_W     = 4;

  logic clk;
  logic rst;

  buff_dly_if #(.DATA_W(DATA_W), .DSEL_W(DSEL_W), .CNT_W(CNT_W)) bus ();

  buff_dly #(
    .DATA_W    (DATA_W),
    .MAX_DEPTH (MAX_DEPTH),
    .DSEL_W    (DSEL_W),
    .CNT_W     (CNT_W)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] data, input logic vld,
                         input logic prm, input logic [3:0] occ, input logic [3:0] lost);
    chk({tag, "_data"},  bus.out_data, data);
    chk({tag, "_vld"},   32'(bus.out_valid), 32'(vld));
    chk({tag, "_prm"},   32'(bus.primed), 32'(prm));
    chk({tag, "_occ"},   32'(bus.occ), 32'(occ));
    chk({tag, "_lost"},  32'(bus.lost_cnt), 32'(lost));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.en      = 1'b0;
    bus.hold    = 1'b0;
    bus.flush   = 1'b0;
    bus.in_data = '0;
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              en;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] exp_data;
    logic              exp_vld;
    logic              exp_prm;
    logic [3:0]        exp_occ;
  } vec_t;

  vec_t tbl[8];

  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] prev_out;
  logic              hold_now;
  logic [3:0]        lost_exp [3];

  initial begin
    // single word at depth 6: visible on edge 6 only
    tbl[0] = '{1'b1, 32'hA5A5_0001, 32'h0,         1'b0, 1'b0, 4'd1};
    tbl[1] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 4'd1};
    tbl[2] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 4'd1};
    tbl[3] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 4'd1};
    tbl[4] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 4'd1};
    tbl[5] = '{1'b0, 32'h0,         32'hA5A5_0001, 1'b1, 1'b1, 4'd1};
    tbl[6] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 4'd0};
    tbl[7] = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 4'd0};
    lost_exp[0] = 4'd8;
    lost_exp[1] = 4'd15;
    lost_exp[2] = 4'd15;

    rst           = 1'b0;
    bus.en        = 1'b0;
    bus.hold      = 1'b0;
    bus.flush     = 1'b0;
    bus.depth_sel = 4'd6;
    bus.in_data   = 32'h1234_5678;
    #12;
    chk_all("reset", 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
    rst = 1'b1;

    // ---- table: depth 6 latency and priming ----
    for (int r = 0; r < 8; r++) begin
      bus.en      = tbl[r].en;
      bus.in_data = tbl[r].din;
      tick();
      chk($sformatf("a%0d_data", r), bus.out_data, tbl[r].exp_data);
      chk($sformatf("a%0d_vld", r), 32'(bus.out_valid), 32'(tbl[r].exp_vld));
      chk($sformatf("a%0d_prm", r), 32'(bus.primed), 32'(tbl[r].exp_prm));
      chk($sformatf("a%0d_occ", r), 32'(bus.occ), 32'(tbl[r].exp_occ));
    end

    // ---- depth 4 stream with a 3-cycle hold ----
    do_reset();
    bus.depth_sel = 4'd4;
    word = 32'd1;
    for (int c = 1; c <= 19; c++) begin
      hold_now = (c >= 7 && c <= 9);
      bus.hold = hold_now;
      if (!hold_now && word <= 32'd12) begin
        bus.en      = 1'b1;
        bus.in_data = word;
        exp_q.push_back(word);
        word = word + 32'd1;
      end else begin
        bus.en      = 1'b0;
        bus.in_data = 32'hDEAD_BEEF;
      end
      prev_out = bus.out_data;
      tick();
      if (hold_now) begin
        chk($sformatf("b%0d_hold_occ", c), 32'(bus.occ), 32'd4);
        chk($sformatf("b%0d_hold_data", c), bus.out_data, prev_out);
      end else begin
        chk($sformatf("b%0d_vld", c), 32'(bus.out_valid), 32'(c >= 4 && c <= 18));
        if (bus.out_valid) begin
          if (exp_q.size() == 0) chk($sformatf("b%0d_extra", c), bus.out_data, 32'hFFFF_FFFF);
          else chk($sformatf("b%0d_seq", c), bus.out_data, exp_q.pop_front());
        end
      end
    end
    bus.hold = 1'b0;
    chk("b_drained", 32'(exp_q.size()), 32'd0);

    // ---- flush under hold at depth 8 with 5 words inside ----
    do_reset();
    bus.depth_sel = 4'd8;
    for (int i = 0; i < 5; i++) begin
      bus.en      = 1'b1;
      bus.in_data = 32'd100 + 32'(i);
      tick();
    end
    chk("c_occ5", 32'(bus.occ), 32'd5);
    bus.flush   = 1'b1;
    bus.hold    = 1'b1;
    bus.in_data = 32'hCAFE_0000;
    tick();
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    bus.en    = 1'b0;
    chk_all("c_flush", 32'h0, 1'b0, 1'b0, 4'd0, 4'd5);

    // ---- clamp: depth_sel 0 -> 1, depth_sel 15 -> 8 ----
    do_reset();
    bus.depth_sel = 4'd0;
    bus.en        = 1'b1;
    bus.in_data   = 32'h0000_0011;
    tick();
    bus.en = 1'b0;
    chk("d0_vld", 32'(bus.out_valid), 32'd1);
    chk("d0_data", bus.out_data, 32'h0000_0011);
    tick();
    chk("d0_gone", 32'(bus.out_valid), 32'd0);

    do_reset();
    bus.depth_sel = 4'd15;
    bus.en        = 1'b1;
    bus.in_data   = 32'h0000_0022;
    for (int e = 1; e <= 8; e++) begin
      tick();
      bus.en = 1'b0;
      chk($sformatf("d15_vld_e%0d", e), 32'(bus.out_valid), 32'(e == 8));
    end
    chk("d15_data", bus.out_data, 32'h0000_0022);

    // ---- depth change 6 -> 3 with a full line ----
    do_reset();
    bus.depth_sel = 4'd6;
    for (int i = 1; i <= 8; i++) begin
      bus.en      = 1'b1;
      bus.in_data = 32'(i);
      tick();
    end
    chk_all("e_full", 32'd3, 1'b1, 1'b1, 4'd6, 4'd0);
    bus.en        = 1'b0;
    bus.depth_sel = 4'd3;
    #1;
    chk("e_tap_now", bus.out_data, 32'd6);
    tick();
    chk_all("e_chg", 32'd7, 1'b1, 1'b0, 4'd2, 4'd0);
    tick();
    chk_all("e_adv1", 32'd8, 1'b1, 1'b0, 4'd1, 4'd0);
    tick();
    chk_all("e_adv2", 32'd0, 1'b0, 1'b0, 4'd0, 4'd0);
    tick();
    chk_all("e_adv3", 32'd0, 1'b0, 1'b1, 4'd0, 4'd0);

    // ---- lost_cnt saturation with CNT_W=4 ----
    do_reset();
    bus.depth_sel = 4'd8;
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 8; i++) begin
        bus.en      = 1'b1;
        bus.in_data = 32'h100 + 32'(i);
        tick();
      end
      bus.en    = 1'b0;
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk($sformatf("f_lost%0d", rep), 32'(bus.lost_cnt), 32'(lost_exp[rep]));
    end

    // ---- asynchronous reset mid-stream ----
    for (int i = 0; i < 8; i++) begin
      bus.en      = 1'b1;
      bus.in_data = 32'h200 + 32'(i);
      tick();
    end
    chk("g_pre_vld", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_all("g_async", 32'h0, 1'b0, 1'b0, 4'd0, 4'd0);
    bus.en = 1'b0;
    rst    = 1'b1;
    tick();
    chk("g_after_lost", 32'(bus.lost_cnt), 32'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/buff_dly.md
BUFF_DLY -- requirements
Module: buff_dly

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits.
REQ-002 Parameter MAX_DEPTH, default 8, number of physical stages (range 2..64).
REQ-003 Parameter DSEL_W, default $clog2(MAX_DEPTH)+1, width of depth_sel and occ.
REQ-004 Parameter CNT_W, default 16, width of lost_cnt.
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  asynchronous, active-low reset.
REQ-007 Port en  input  1  high: capture in_data as a valid word; low: insert an invalid zero word.
REQ-008 Port hold  input  1  high: freeze all stages.
REQ-009 Port flush  input  1  synchronous clear of all stages.
REQ-010 Port depth_sel  input  DSEL_W  runtime delay in cycles.
REQ-011 Port in_data  input  DATA_W  input word.
REQ-012 Port out_data  output  DATA_W  word at the selected tap.
REQ-013 Port out_valid  output  1  valid flag at the selected tap.
REQ-014 Port primed  output  1  the line has advanced at least D_eff times since the last reset, flush or depth change.
REQ-015 Port occ  output  DSEL_W  count of valid words in stages 1..D_eff.
REQ-016 Port lost_cnt  output  CNT_W  valid words discarded by flush, saturating.

Function
REQ-017 D_eff SHALL be depth_sel clamped: 0 maps to 1, values above MAX_DEPTH map to MAX_DEPTH.
REQ-018 Advance condition: flush=0 and hold=0.
REQ-019 On advance, stage 1 data SHALL load en ? in_data : 0 and stage 1 valid SHALL load en; stage k SHALL load stage k-1 for k=2..MAX_DEPTH.
REQ-020 out_data/out_valid SHALL be the data/valid of stage D_eff; latency from in_data to out_data is exactly D_eff advance cycles.
REQ-021 The output mux SHALL select only stage registers; no combinational path SHALL exist from in_data or en to any output.
REQ-022 With hold=1 and flush=0, all stages, outputs, occ and the prime counter SHALL be unchanged.
REQ-023 With flush=1, all stage data and valids SHALL clear to 0 on the next edge, regardless of hold or en; the in_data of that cycle SHALL be dropped.
REQ-024 On a flush edge, lost_cnt SHALL add the number of valid stages among all MAX_DEPTH stages, saturating at 2^CNT_W-1.
REQ-025 The prime counter SHALL increment on each advance, saturate at D_eff, and clear to 0 on flush.
REQ-026 A change of D_eff (registered previous value compared) SHALL clear the prime counter; stage contents are kept and the tap switches the cycle depth_sel changes.
REQ-027 primed SHALL be high when prime counter >= D_eff.
REQ-028 occ SHALL be the popcount of valid flags in stages 1..D_eff.
REQ-029 Words in stages beyond D_eff SHALL continue shifting; they are not counted in occ but are counted by lost_cnt on flush.

Reset
REQ-030 rst low SHALL asynchronously clear all stage data and valids, the prime counter and lost_cnt to 0, and set the registered previous D_eff to the clamped DEF_DEPTH (6).
REQ-031 Out of reset: out_data=0, out_valid=0, primed=0, occ=0, lost_cnt=0.
REQ-032 Reset asserted mid-operation SHALL discard in-flight words without incrementing lost_cnt.

Structure
REQ-033 Package buff_dly_pkg SHALL hold DATA_W/MAX_DEPTH/CNT_W defaults, DEF_DEPTH=6 and the depth-clamp function.
REQ-034 Sub-module buff_dly_popcnt (parametrised valid-vector popcount) SHALL be used for occ and the flush loss count.

Verification
REQ-035 depth_sel=6, en=1, in_data=0xA5A5_0001 one cycle then en=0 -> out_data=0xA5A5_0001 and out_valid=1 on exactly the 6th edge only; primed rises at edge 6.
REQ-036 depth_sel=4, stream 1,2,3,... with hold=1 for 3 cycles mid-stream -> output sequence is gapless 1,2,3,..., each delayed by 4 plus 3 hold cycles; occ stays 4 during hold.
REQ-037 depth_sel=8, 5 valid words entered, then flush=1 with hold=1 -> next edge all outputs 0, occ=0, primed=0, lost_cnt=5.
REQ-038 depth_sel=0 and depth_sel=15 (MAX_DEPTH=8) -> latency 1 and 8 respectively.
REQ-039 Change depth_sel from 6 to 3 with the line full -> the tap switches immediately, primed drops and re-rises after 3 advances; no data is cleared.
REQ-040 CNT_W=4, repeated flushes of 8 valid words -> lost_cnt saturates at 15; rst low mid-stream -> all outputs 0 asynchronously.
